reorder_buffer: RTL

- Circular in-order reorder buffer.
- Hands out the ROB id that the rename table records for each renaming instruction.
- Collects out-of-order writeback results and serves operand lookups by ROB id.
- Retires the head entry in program order, driving the commit / commit_rd / commit_rob_id interface that the rename table consumes.

---
 rtl/reorder_buffer_if.sv | 55 +++++
 rtl/reorder_buffer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// Bundle of decode, writeback, lookup and commit signals around the reorder buffer.
// slave: the buffer itself; master: the decode/execute/rename side.
interface reorder_buffer_if #(
  parameter int ROB_ENTRY_WIDTH     = 3,
  parameter int ARCH_REG_INDEX_SIZE = 5,
  parameter int XLEN                = 32
);
  // Allocation from decode
  logic                           alloc_req;
  logic                           alloc_writes_rd;
  logic [ARCH_REG_INDEX_SIZE-1:0] alloc_rd;
  logic [ROB_ENTRY_WIDTH-1:0]     alloc_rob_id;
  logic                           full;
  logic                           empty;
  logic [ROB_ENTRY_WIDTH:0]       count;

  // Writeback from functional units
  logic                           wb_valid;
  logic [ROB_ENTRY_WIDTH-1:0]     wb_rob_id;
  logic [XLEN-1:0]                wb_value;
  logic                           wb_exception;

  // Operand lookup
  logic [ROB_ENTRY_WIDTH-1:0]     rs1_rob_entry;
  logic [XLEN-1:0]                rs1_value;
  logic                           rs1_ready;
  logic [ROB_ENTRY_WIDTH-1:0]     rs2_rob_entry;
  logic [XLEN-1:0]                rs2_value;
  logic                           rs2_ready;

  // Retirement towards the rename table / register file
  logic                           commit;
  logic [ARCH_REG_INDEX_SIZE-1:0] commit_rd;
  logic [ROB_ENTRY_WIDTH-1:0]     commit_rob_id;
  logic [XLEN-1:0]                commit_value;
  logic                           flush;

  modport slave (
    input  alloc_req, alloc_writes_rd, alloc_rd,
    input  wb_valid, wb_rob_id, wb_value, wb_exception,
    input  rs1_rob_entry, rs2_rob_entry,
    output alloc_rob_id, full, empty, count,
    output rs1_value, rs1_ready, rs2_value, rs2_ready,
    output commit, commit_rd, commit_rob_id, commit_value, flush
  );

  modport master (
    output alloc_req, alloc_writes_rd, alloc_rd,
    output wb_valid, wb_rob_id, wb_value, wb_exception,
    output rs1_rob_entry, rs2_rob_entry,
    input  alloc_rob_id, full, empty, count,
    input  rs1_value, rs1_ready, rs2_value, rs2_ready,
    input  commit, commit_rd, commit_rob_id, commit_value, flush
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates ids, collects writebacks, retires one entry per cycle.
// Optional macro ROB_WB_BYPASS_EN forwards a same-cycle writeback to the operand lookups.
module reorder_buffer #(
  parameter int ROB_ENTRIES         = 8,
  parameter int ROB_ENTRY_WIDTH     = 3,
  parameter int ARCH_REG_INDEX_SIZE = 5,
  parameter int XLEN                = 32
) (
  input  logic               clk,
  input  logic               reset,
  reorder_buffer_if.slave    rob
);

  typedef logic [ROB_ENTRY_WIDTH-1:0] id_t;
  typedef logic [ROB_ENTRY_WIDTH:0]   cnt_t;

  // Per-entry status bits; payload lives in arrays without reset
  logic [ROB_ENTRIES-1:0]         valid_q, valid_d;
  logic [ROB_ENTRIES-1:0]         ready_q, ready_d;
  logic [ROB_ENTRIES-1:0]         exc_q, exc_d;
  logic                           wrd_q   [ROB_ENTRIES];
  logic [ARCH_REG_INDEX_SIZE-1:0] rd_q    [ROB_ENTRIES];
  logic [XLEN-1:0]                value_q [ROB_ENTRIES];

  id_t  head_q, head_d;
  id_t  tail_q, tail_d;
  cnt_t count_q, count_d;

  logic full_w, empty_w;
  logic alloc_ok;
  logic wb_hit;
  logic commit_w, flush_w;

  logic [ROB_ENTRIES-1:0] alloc_sel;
  logic [ROB_ENTRIES-1:0] commit_sel;
  logic [ROB_ENTRIES-1:0] wb_sel;

  assign full_w  = (count_q == cnt_t'(ROB_ENTRIES));
  assign empty_w = (count_q == '0);

  // Head decision uses only registered state, so a writeback to head is seen one cycle later
  assign commit_w = valid_q[head_q] & ready_q[head_q] & ~exc_q[head_q];
  assign flush_w  = valid_q[head_q] & ready_q[head_q] &  exc_q[head_q];

  // A commit in the same cycle never opens a slot for a refused allocation
  assign alloc_ok = rob.alloc_req & ~full_w & ~flush_w;
  assign wb_hit   = rob.wb_valid & valid_q[rob.wb_rob_id];

  // One-hot per-entry selects for allocation, retirement and writeback
  for (genvar gi = 0; gi < ROB_ENTRIES; gi++) begin : g_entry_sel
    assign alloc_sel[gi]  = alloc_ok & (tail_q == id_t'(gi));
    assign commit_sel[gi] = commit_w & (head_q == id_t'(gi));
    assign wb_sel[gi]     = rob.wb_valid & valid_q[gi] & (rob.wb_rob_id == id_t'(gi));
  end

  always_comb begin
    valid_d = (valid_q | alloc_sel) & ~commit_sel;
    ready_d = (ready_q | wb_sel) & ~alloc_sel;
    exc_d   = ((exc_q & ~wb_sel) | (wb_sel & {ROB_ENTRIES{rob.wb_exception}})) & ~alloc_sel;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_w) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_ok) tail_d = tail_q + id_t'(1);
      if (commit_w) head_d = head_q + id_t'(1);
      count_d = count_q + cnt_t'(alloc_ok) - cnt_t'(commit_w);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      ready_q <= '0;
      exc_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      exc_q   <= exc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage; every read is qualified by valid/ready so no reset is needed
  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      wrd_q[tail_q] <= rob.alloc_writes_rd;
      rd_q[tail_q]  <= rob.alloc_rd;
    end
    if (wb_hit) begin
      value_q[rob.wb_rob_id] <= rob.wb_value;
    end
  end

  // Operand lookups, indexed 0 = rs1, 1 = rs2
  id_t             lk_id  [2];
  logic [1:0]      lk_rdy;
  logic [XLEN-1:0] lk_val [2];

  assign lk_id[0] = rob.rs1_rob_entry;
  assign lk_id[1] = rob.rs2_rob_entry;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
    logic stored_hit;
    logic byp_hit;
    assign stored_hit = valid_q[lk_id[gi]] & ready_q[lk_id[gi]];
`ifdef ROB_WB_BYPASS_EN
    assign byp_hit = rob.wb_valid & valid_q[lk_id[gi]] & (rob.wb_rob_id == lk_id[gi]);
`else
    assign byp_hit = 1'b0;
`endif
    // The in-flight writeback is newer than anything stored, so it wins
    assign lk_rdy[gi] = stored_hit | byp_hit;
    assign lk_val[gi] = byp_hit    ? rob.wb_value :
                        stored_hit ? value_q[lk_id[gi]] : '0;
  end

  assign rob.rs1_ready = lk_rdy[0];
  assign rob.rs1_value = lk_val[0];
  assign rob.rs2_ready = lk_rdy[1];
  assign rob.rs2_value = lk_val[1];

  assign rob.alloc_rob_id  = tail_q;
  assign rob.full          = full_w;
  assign rob.empty         = empty_w;
  assign rob.count         = count_q;
  assign rob.commit        = commit_w;
  assign rob.flush         = flush_w;
  assign rob.commit_rob_id = commit_w ? head_q : '0;
  assign rob.commit_value  = commit_w ? value_q[head_q] : '0;
  assign rob.commit_rd     = (commit_w & wrd_q[head_q]) ? rd_q[head_q] : '0;

endmodule
